fs_seq_sub: RTL and testbench

- Parametrised, multi-cycle borrow-chain subtractor for the nroot datapath.
- Computes out = a - b - bin over DATA_WIDTH bits, CHUNK_WIDTH bits per clock, least-significant chunk first.
- A registered borrow carries between chunks, trading latency for area on wide mantissa/remainder subtractions.
- Valid/ready handshake on input and output; also reports final borrow and a zero flag.

---
 rtl/fs_seq_sub.sv | 167 ++++++++++++++++
 tb/tb_fs_seq_sub.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fs_seq_sub.sv
// fs_seq_sub: multi-cycle borrow-chain subtractor, out = a - b - bin.
// Processes CHUNK_WIDTH bits per clock, LS chunk first, with a
// registered borrow between chunks. Valid/ready on both sides.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   in_valid/in_ready   operand handshake (a, b, bin)
//   out_valid/out_ready result handshake (out, bout, zero)
// Optional macro FS_SEQ_SIGNED_FLAGS_EN adds registered outputs
//   ovf (signed overflow) and slt (signed a < b + bin).
module fs_seq_sub #(
    parameter int DATA_WIDTH  = 24,
    parameter int CHUNK_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic                  bin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out,
    output logic                  bout,
    output logic                  zero
`ifdef FS_SEQ_SIGNED_FLAGS_EN
    ,
    output logic                  ovf,
    output logic                  slt
`endif
);

    localparam int N     = DATA_WIDTH / CHUNK_WIDTH;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    generate
        if (DATA_WIDTH % CHUNK_WIDTH != 0) begin : g_bad_cfg
            $error("DATA_WIDTH must be a multiple of CHUNK_WIDTH");
        end
    endgenerate

    logic [1:0]            r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_borrow;
    logic [DATA_WIDTH-1:0] r_a;
    logic [DATA_WIDTH-1:0] r_b;
    logic [DATA_WIDTH-1:0] r_res;
    logic [DATA_WIDTH-1:0] r_out;
    logic                  r_bout;
    logic                  r_zero;

    logic [CHUNK_WIDTH-1:0] w_a_k;
    logic [CHUNK_WIDTH-1:0] w_b_k;
    logic [CHUNK_WIDTH:0]   w_sub;
    logic [DATA_WIDTH-1:0]  w_res_next;
    logic                   w_last;

    // Chunk selection by constant-index mux keeps every slice static.
    always_comb begin
        w_a_k = '0;
        w_b_k = '0;
        for (int i = 0; i < N; i++) begin
            if (r_cnt == CNT_W'(i)) begin
                w_a_k = r_a[i*CHUNK_WIDTH +: CHUNK_WIDTH];
                w_b_k = r_b[i*CHUNK_WIDTH +: CHUNK_WIDTH];
            end
        end
    end

    // One extra bit: its MSB is the borrow out of this chunk.
    assign w_sub = {1'b0, w_a_k}
                 - {1'b0, w_b_k}
                 - (CHUNK_WIDTH+1)'(r_borrow);

    always_comb begin
        w_res_next = r_res;
        for (int i = 0; i < N; i++) begin
            if (r_cnt == CNT_W'(i)) begin
                w_res_next[i*CHUNK_WIDTH +: CHUNK_WIDTH] =
                    w_sub[CHUNK_WIDTH-1:0];
            end
        end
    end

    assign w_last = (r_cnt == LAST);

`ifdef FS_SEQ_SIGNED_FLAGS_EN
    logic r_ovf;
    logic r_slt;
    logic w_ovf;

    assign w_ovf = (r_a[DATA_WIDTH-1] != r_b[DATA_WIDTH-1])
                 & (w_res_next[DATA_WIDTH-1] != r_a[DATA_WIDTH-1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
            r_slt <= 1'b0;
        end else if (r_state == S_RUN && w_last) begin
            r_ovf <= w_ovf;
            r_slt <= w_res_next[DATA_WIDTH-1] ^ w_ovf;
        end
    end

    assign ovf = r_ovf;
    assign slt = r_slt;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_borrow <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_res    <= '0;
            r_out    <= '0;
            r_bout   <= 1'b0;
            r_zero   <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a      <= a;
                        r_b      <= b;
                        r_borrow <= bin;
                        r_cnt    <= '0;
                        r_state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_res    <= w_res_next;
                    r_borrow <= w_sub[CHUNK_WIDTH];
                    if (w_last) begin
                        r_cnt   <= '0;
                        r_out   <= w_res_next;
                        r_bout  <= w_sub[CHUNK_WIDTH];
                        r_zero  <= (w_res_next == '0);
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign out       = r_out;
    assign bout      = r_bout;
    assign zero      = r_zero;

endmodule

// File: tb/tb_fs_seq_sub.sv
// tb_fs_seq_sub: directed + random bench for fs_seq_sub.
// Three instances (N = 4, 1, 8) share stimulus and a reference model.
module tb_fs_seq_sub;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic       out_ready;

    logic [2:0] ir;
    logic [2:0] ov;
    logic [2:0] bo;
    logic [2:0] zr;
    logic [7:0] ot [3];
`ifdef FS_SEQ_SIGNED_FLAGS_EN
    logic [2:0] of;
    logic [2:0] sl;
`endif

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    int         exp_lat [3] = '{4, 1, 8};
    int         cap_lat [3];
    logic [7:0] cap_out [3];
    logic [2:0] cap_bo;
    logic [2:0] cap_zr;
`ifdef FS_SEQ_SIGNED_FLAGS_EN
    logic [2:0] cap_of;
    logic [2:0] cap_sl;
`endif

    fs_seq_sub #(.DATA_WIDTH(8), .CHUNK_WIDTH(2)) u_n4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(ir[0]),
        .a(a), .b(b), .bin(bin),
        .out_valid(ov[0]), .out_ready(out_ready),
        .out(ot[0]), .bout(bo[0]), .zero(zr[0])
`ifdef FS_SEQ_SIGNED_FLAGS_EN
        , .ovf(of[0]), .slt(sl[0])
`endif
    );

    fs_seq_sub #(.DATA_WIDTH(8), .CHUNK_WIDTH(8)) u_n1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(ir[1]),
        .a(a), .b(b), .bin(bin),
        .out_valid(ov[1]), .out_ready(out_ready),
        .out(ot[1]), .bout(bo[1]), .zero(zr[1])
`ifdef FS_SEQ_SIGNED_FLAGS_EN
        , .ovf(of[1]), .slt(sl[1])
`endif
    );

    fs_seq_sub #(.DATA_WIDTH(8), .CHUNK_WIDTH(1)) u_n8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(ir[2]),
        .a(a), .b(b), .bin(bin),
        .out_valid(ov[2]), .out_ready(out_ready),
        .out(ot[2]), .bout(bo[2]), .zero(zr[2])
`ifdef FS_SEQ_SIGNED_FLAGS_EN
        , .ovf(of[2]), .slt(sl[2])
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operand values.
    task automatic model(input logic [7:0] ma, input logic [7:0] mb,
                         input logic mbin,
                         output logic [7:0] mo, output logic mbo,
                         output logic mz, output logic mov,
                         output logic mslt);
        int ud;
        int sd;
        ud   = int'(ma) - int'(mb) - int'(mbin);
        sd   = int'($signed(ma)) - int'($signed(mb)) - int'(mbin);
        mo   = 8'((ud + 256) % 256);
        mbo  = (ud < 0);
        mz   = (mo == 8'h00);
        mov  = (sd < -128) || (sd > 127);
        mslt = (sd < 0);
    endtask

    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb,
                          input logic tbin);
        logic [7:0] eo;
        logic       ebo, ez, eov, eslt;
        logic [2:0] seen;
        model(ta, tb, tbin, eo, ebo, ez, eov, eslt);
        @(posedge clk); #1;
        check("pre_in_ready", 32'(ir), 32'h7);
        a = ta; b = tb; bin = tbin; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
        seen = '0;
        for (int d = 0; d < 3; d++) cap_lat[d] = -1;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                if (!seen[d] && ov[d]) begin
                    seen[d]    = 1'b1;
                    cap_lat[d] = k;
                    cap_out[d] = ot[d];
                    cap_bo[d]  = bo[d];
                    cap_zr[d]  = zr[d];
`ifdef FS_SEQ_SIGNED_FLAGS_EN
                    cap_of[d]  = of[d];
                    cap_sl[d]  = sl[d];
`endif
                end
            end
        end
        for (int d = 0; d < 3; d++) begin
            check($sformatf("lat%0d", d), 32'(cap_lat[d]), 32'(exp_lat[d]));
            check($sformatf("out%0d", d), 32'(cap_out[d]), 32'(eo));
            check($sformatf("bout%0d", d), 32'(cap_bo[d]), 32'(ebo));
            check($sformatf("zero%0d", d), 32'(cap_zr[d]), 32'(ez));
`ifdef FS_SEQ_SIGNED_FLAGS_EN
            check($sformatf("ovf%0d", d), 32'(cap_of[d]), 32'(eov));
            check($sformatf("slt%0d", d), 32'(cap_sl[d]), 32'(eslt));
`endif
        end
    endtask

    initial begin
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        bin       = 1'b0;
        out_ready = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("rst_in_ready", 32'(ir), 32'h7);
        check("rst_out_valid", 32'(ov), 32'h0);
        check("rst_out", 32'(ot[0]), 32'h0);
        check("rst_bout", 32'(bo), 32'h0);
        check("rst_zero", 32'(zr), 32'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        run_op(8'h5A, 8'h3C, 1'b0);
        check("basic_out", 32'(cap_out[0]), 32'h1E);
        check("basic_bout", 32'(cap_bo[0]), 32'h0);

        run_op(8'h10, 8'h20, 1'b0);
        check("wrap_out", 32'(cap_out[0]), 32'hF0);
        check("wrap_bout", 32'(cap_bo[0]), 32'h1);

        run_op(8'h00, 8'h00, 1'b1);
        check("bin_out", 32'(cap_out[0]), 32'hFF);
        check("bin_bout", 32'(cap_bo[0]), 32'h1);
        check("bin_zero", 32'(cap_zr[0]), 32'h0);
        check("hold_after_hs", 32'(ot[0]), 32'hFF);

        // Reset two RUN cycles into an operation.
        @(posedge clk); #1;
        a = 8'hFF; b = 8'h01; bin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        check("mid_run_valid", 32'(ov[0]), 32'h0);
        rst_n = 1'b0;
        #1;
        check("abort_valid", 32'(ov), 32'h0);
        check("abort_out0", 32'(ot[0]), 32'h0);
        check("abort_out1", 32'(ot[1]), 32'h0);
        check("abort_bout", 32'(bo), 32'h0);
        check("abort_ready", 32'(ir), 32'h7);
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_op(8'h02, 8'h01, 1'b0);
        check("post_rst_out", 32'(cap_out[0]), 32'h01);
        check("post_rst_bout", 32'(cap_bo[0]), 32'h0);

        // Backpressure with equal operands.
        out_ready = 1'b0;
        @(posedge clk); #1;
        a = 8'h33; b = 8'h33; bin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("bp_valid_at_N", 32'(ov[0]), 32'h1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (i == 3) begin
                a = 8'h11; b = 8'h01; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            check($sformatf("bp_valid%0d", i), 32'(ov[0]), 32'h1);
            check($sformatf("bp_ready%0d", i), 32'(ir[0]), 32'h0);
            check($sformatf("bp_out%0d", i), 32'(ot[0]), 32'h0);
            check($sformatf("bp_zero%0d", i), 32'(zr[0]), 32'h1);
            check($sformatf("bp_bout%0d", i), 32'(bo[0]), 32'h0);
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_rel_valid", 32'(ov[0]), 32'h0);
        check("bp_rel_ready", 32'(ir[0]), 32'h1);
        check("bp_rel_out", 32'(ot[0]), 32'h0);
        check("bp_rel_zero", 32'(zr[0]), 32'h1);
        repeat (2) @(posedge clk);

`ifdef FS_SEQ_SIGNED_FLAGS_EN
        run_op(8'h80, 8'h01, 1'b0);
        check("sf1_out", 32'(cap_out[0]), 32'h7F);
        check("sf1_ovf", 32'(cap_of[0]), 32'h1);
        check("sf1_slt", 32'(cap_sl[0]), 32'h1);
        run_op(8'h05, 8'hFB, 1'b0);
        check("sf2_out", 32'(cap_out[0]), 32'h0A);
        check("sf2_ovf", 32'(cap_of[0]), 32'h0);
        check("sf2_slt", 32'(cap_sl[0]), 32'h0);
`endif

        for (int t = 0; t < 1000; t++) begin
            run_op(8'($urandom), 8'($urandom), 1'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
